multicycle_control: RTL and testbench

- Multicycle RISC-V (RV32I) control unit; successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a req/ready handshake.
- Adds LUI/AUIPC/JAL/JALR decoding, a memory-wait timeout, and an instructions-retired counter.
- Sits between the instruction register and the datapath muxes/enables.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/multicycle_control_mem_wait_timer.sv | 51 +++++
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and the bundled control-output struct.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_TARGET = 2'd1;
    localparam logic [1:0] PCSRC_ALU    = 2'd2;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       branch;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] memtoreg;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter with sticky timeout flag; expire_o pulses on the
// WAIT_MAX-th consecutive unanswered request cycle (WAIT_MAX=0 disables it).
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic ready_i,
    input  logic clear_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int              CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0]   LAST = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic            EN   = (WAIT_MAX > 0) ? 1'b1 : 1'b0;

    logic [CW-1:0] count_d, count_q;
    logic          timeout_d, timeout_q;
    logic          expire_s;

    // Ready in the final allowed cycle wins over the timeout.
    assign expire_s = EN & req_i & ~ready_i & (count_q == LAST);

    // Next-state for the wait counter and sticky flag.
    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q | expire_s;
        if (clear_i || ready_i || !req_i || expire_s) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign expire_o  = expire_s;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait
// timeout and retired-instruction counter. Optional macro: ILLEGAL_TRAP_EN.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             irwrite_o,
    output logic             pcwrite_o,
    output logic [1:0]       pcsrc_o,
    output logic             branch_o,
    output logic             regwrite_o,
    output logic             alusrc_o,
    output logic [1:0]       memtoreg_o,
    output logic [1:0]       aluop_o,
    output logic [2:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] instret_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_o
`endif
);

    logic [2:0]       state_d, state_q;
    logic [6:0]       op_d, op_q;
    logic [CNT_W-1:0] instret_d, instret_q;
    logic             retire_s;
    logic             expire_s;
    logic             wait_req_s;
    ctrl_t            ctrl_s, ctrl_out_s;

    assign wait_req_s = (state_q == S_FETCH) || (state_q == S_MEM);

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (wait_req_s),
        .ready_i  (mem_ready_i),
        .clear_i  (state_d != state_q),
        .expire_o (expire_s),
        .timeout_o(timeout_o)
    );

    // Next-state, control decode and retire detection.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        retire_s = 1'b0;
        ctrl_s   = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_req = 1'b1;
                if (mem_ready_i) begin
                    ctrl_s.irwrite = 1'b1;
                    ctrl_s.pcwrite = 1'b1;
                    ctrl_s.pcsrc   = PCSRC_PC4;
                    state_d        = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d    = opcode_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        ctrl_s.aluop = ALUOP_FUNCT;
                        state_d      = S_WB;
                    end
                    OP_ITYPE: begin
                        ctrl_s.aluop  = ALUOP_FUNCT;
                        ctrl_s.alusrc = 1'b1;
                        state_d       = S_WB;
                    end
                    OP_LUI, OP_AUIPC: begin
                        ctrl_s.aluop  = ALUOP_ADD;
                        ctrl_s.alusrc = 1'b1;
                        state_d       = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl_s.aluop  = ALUOP_ADD;
                        ctrl_s.alusrc = 1'b1;
                        state_d       = S_MEM;
                    end
                    OP_BRANCH: begin
                        ctrl_s.aluop  = ALUOP_BRANCH;
                        ctrl_s.branch = 1'b1;
                        ctrl_s.pcsrc  = PCSRC_TARGET;
                        retire_s      = 1'b1;
                        state_d       = S_FETCH;
                    end
                    OP_JAL: begin
                        ctrl_s.pcwrite = 1'b1;
                        ctrl_s.pcsrc   = PCSRC_TARGET;
                        state_d        = S_WB;
                    end
                    OP_JALR: begin
                        ctrl_s.alusrc  = 1'b1;
                        ctrl_s.pcwrite = 1'b1;
                        ctrl_s.pcsrc   = PCSRC_ALU;
                        state_d        = S_WB;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.mem_we  = (op_q == OP_STORE);
                if (mem_ready_i) begin
                    if (op_q == OP_STORE) begin
                        retire_s = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (expire_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                ctrl_s.regwrite = 1'b1;
                if (op_q == OP_LOAD) begin
                    ctrl_s.memtoreg = MTR_MEM;
                end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
                    ctrl_s.memtoreg = MTR_PC4;
                end else begin
                    ctrl_s.memtoreg = MTR_ALU;
                end
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
        instret_d = retire_s ? (instret_q + CNT_W'(1)) : instret_q;
    end

    // State, latched opcode and retire counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            instret_q <= instret_d;
        end
    end

    // Reset suppresses every write-enable in the cycle it is asserted.
    assign ctrl_out_s = rst_i ? ctrl_t'('0) : ctrl_s;

    assign mem_req_o  = ctrl_out_s.mem_req;
    assign mem_we_o   = ctrl_out_s.mem_we;
    assign irwrite_o  = ctrl_out_s.irwrite;
    assign pcwrite_o  = ctrl_out_s.pcwrite;
    assign pcsrc_o    = ctrl_out_s.pcsrc;
    assign branch_o   = ctrl_out_s.branch;
    assign regwrite_o = ctrl_out_s.regwrite;
    assign alusrc_o   = ctrl_out_s.alusrc;
    assign memtoreg_o = ctrl_out_s.memtoreg;
    assign aluop_o    = ctrl_out_s.aluop;
    assign state_o    = state_q;
    assign instret_o  = instret_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_o  = ~rst_i & (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle bench for multicycle_control (WAIT_MAX=4, CNT_W=4);
// expected outputs are queued as stimulus is driven and checked at negedge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, irwrite, pcwrite, branch, regwrite, alusrc, timeout;
    logic [1:0] pcsrc, memtoreg, aluop;
    logic [2:0] state;
    logic [3:0] instret;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    // Control vector: {req, we, ir, pcw, pcsrc[2], br, rw, alusrc, mtr[2], aluop[2]}
    localparam logic [12:0] C_ZERO    = 13'b0_0_0_0_00_0_0_0_00_00;
    localparam logic [12:0] C_F_WAIT  = 13'b1_0_0_0_00_0_0_0_00_00;
    localparam logic [12:0] C_F_RDY   = 13'b1_0_1_1_00_0_0_0_00_00;
    localparam logic [12:0] C_EX_R    = 13'b0_0_0_0_00_0_0_0_00_10;
    localparam logic [12:0] C_EX_I    = 13'b0_0_0_0_00_0_0_1_00_10;
    localparam logic [12:0] C_EX_ADDI = 13'b0_0_0_0_00_0_0_1_00_00;
    localparam logic [12:0] C_EX_BR   = 13'b0_0_0_0_01_1_0_0_00_01;
    localparam logic [12:0] C_EX_JAL  = 13'b0_0_0_1_01_0_0_0_00_00;
    localparam logic [12:0] C_EX_JALR = 13'b0_0_0_1_10_0_0_1_00_00;
    localparam logic [12:0] C_MEM_LD  = 13'b1_0_0_0_00_0_0_0_00_00;
    localparam logic [12:0] C_MEM_ST  = 13'b1_1_0_0_00_0_0_0_00_00;
    localparam logic [12:0] C_WB_ALU  = 13'b0_0_0_0_00_0_1_0_00_00;
    localparam logic [12:0] C_WB_LD   = 13'b0_0_0_0_00_0_1_0_01_00;
    localparam logic [12:0] C_WB_J    = 13'b0_0_0_0_00_0_1_0_10_00;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] JR_OP  = 7'b1100111;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] c;
        logic        to;
        logic [3:0]  ir;
        logic        ill;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic       exp_to;
    logic [3:0] n_ret;

    multicycle_control #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .opcode_i   (opcode),
        .mem_ready_i(mem_ready),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .irwrite_o  (irwrite),
        .pcwrite_o  (pcwrite),
        .pcsrc_o    (pcsrc),
        .branch_o   (branch),
        .regwrite_o (regwrite),
        .alusrc_o   (alusrc),
        .memtoreg_o (memtoreg),
        .aluop_o    (aluop),
        .state_o    (state),
        .timeout_o  (timeout),
        .instret_o  (instret)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_o  (illegal)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    always #5 clk = ~clk;

    // Scoreboard: pop one expected entry per cycle, compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 4;
            assert (state === e.st) else begin
                errors = errors + 1;
                $error("FAIL state: got %0d expected %0d", state, e.st);
            end
            assert ({mem_req, mem_we, irwrite, pcwrite, pcsrc, branch, regwrite, alusrc, memtoreg, aluop} === e.c) else begin
                errors = errors + 1;
                $error("FAIL ctrl (state %0d): got %b expected %b", e.st,
                       {mem_req, mem_we, irwrite, pcwrite, pcsrc, branch, regwrite, alusrc, memtoreg, aluop}, e.c);
            end
            assert (timeout === e.to) else begin
                errors = errors + 1;
                $error("FAIL timeout: got %b expected %b", timeout, e.to);
            end
            assert (instret === e.ir) else begin
                errors = errors + 1;
                $error("FAIL instret: got %0d expected %0d", instret, e.ir);
            end
            checks = checks + 1;
            assert (illegal === e.ill) else begin
                errors = errors + 1;
                $error("FAIL illegal: got %b expected %b", illegal, e.ill);
            end
        end
    end

    task automatic cyc(input logic [6:0] op, input logic rdy, input logic rs,
                       input logic [2:0] st, input logic [12:0] c, input logic ill);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        rst       = rs;
        exp_q.push_back('{st, c, exp_to, n_ret, ill});
    endtask

    task automatic instr4(input logic [6:0] op, input logic [12:0] ex, input logic [12:0] wb);
        cyc(op, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(op, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(op, 1'b1, 1'b0, 3'd2, ex, 1'b0);
        cyc(op, 1'b1, 1'b0, 3'd4, wb, 1'b0);
        n_ret = n_ret + 4'd1;
    endtask

    task automatic branch3();
        cyc(BR_OP, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(BR_OP, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(BR_OP, 1'b1, 1'b0, 3'd2, C_EX_BR, 1'b0);
        n_ret = n_ret + 4'd1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        exp_to    = 1'b0;
        n_ret     = 4'd0;
        @(posedge clk);
        #1;
        // Reset held: outputs forced low, state FETCH
        cyc(7'd0, 1'b1, 1'b1, 3'd0, C_ZERO, 1'b0);

        instr4(R_OP, C_EX_R, C_WB_ALU);

        // Load with ready delayed three cycles in MEM (ready wins on the last one)
        cyc(LD_OP, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(LD_OP, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(LD_OP, 1'b1, 1'b0, 3'd2, C_EX_ADDI, 1'b0);
        for (int i = 0; i < 3; i++) cyc(LD_OP, 1'b0, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc(LD_OP, 1'b1, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc(LD_OP, 1'b1, 1'b0, 3'd4, C_WB_LD, 1'b0);
        n_ret = n_ret + 4'd1;

        // Store, immediate ready
        cyc(ST_OP, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(ST_OP, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(ST_OP, 1'b1, 1'b0, 3'd2, C_EX_ADDI, 1'b0);
        cyc(ST_OP, 1'b1, 1'b0, 3'd3, C_MEM_ST, 1'b0);
        n_ret = n_ret + 4'd1;

        branch3();
        instr4(JAL_OP, C_EX_JAL, C_WB_J);
        instr4(JR_OP, C_EX_JALR, C_WB_J);
        instr4(I_OP, C_EX_I, C_WB_ALU);
        instr4(LUI_OP, C_EX_ADDI, C_WB_ALU);

        // Fetch timeout after four unanswered cycles; nothing retired
        for (int i = 0; i < 4; i++) cyc(R_OP, 1'b0, 1'b0, 3'd0, C_F_WAIT, 1'b0);
        exp_to = 1'b1;
        instr4(R_OP, C_EX_R, C_WB_ALU);

        // Seven more branches bring the 4-bit counter to 16 -> wraps to 0
        for (int i = 0; i < 7; i++) branch3();

        // Illegal opcode
        cyc(BAD_OP, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(BAD_OP, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(BAD_OP, 1'b1, 1'b0, 3'd2, C_ZERO, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        cyc(BAD_OP, 1'b1, 1'b0, 3'd5, C_ZERO, 1'b1);
        cyc(BAD_OP, 1'b1, 1'b0, 3'd5, C_ZERO, 1'b1);
        cyc(BAD_OP, 1'b1, 1'b1, 3'd5, C_ZERO, 1'b0);
        exp_to = 1'b0;
        n_ret  = 4'd0;
`endif

        // Reset asserted mid-MEM discards the store
        cyc(ST_OP, 1'b1, 1'b0, 3'd0, C_F_RDY, 1'b0);
        cyc(ST_OP, 1'b1, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc(ST_OP, 1'b0, 1'b0, 3'd2, C_EX_ADDI, 1'b0);
        cyc(ST_OP, 1'b0, 1'b0, 3'd3, C_MEM_ST, 1'b0);
        cyc(ST_OP, 1'b1, 1'b1, 3'd3, C_ZERO, 1'b0);
        exp_to = 1'b0;
        n_ret  = 4'd0;
        cyc(R_OP, 1'b0, 1'b0, 3'd0, C_F_WAIT, 1'b0);
        instr4(R_OP, C_EX_R, C_WB_ALU);
        cyc(R_OP, 1'b0, 1'b0, 3'd0, C_F_WAIT, 1'b0);

        @(posedge clk);
        #1;
        checks = checks + 1;
        assert (exp_q.size() === 0) else begin
            errors = errors + 1;
            $error("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
